// File: rtl/wb_arb_queue.sv
// wb_arb_queue: round-robin writeback arbiter feeding an in-order queue that drains
// one entry per cycle to the regfile port, with forwarding lookup and retire counter.
module wb_arb_queue #(
  parameter int XLEN    = 64,
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         src_valid_i,
  output logic [NUM_SRC-1:0]         src_ready_o,
  input  logic [5*NUM_SRC-1:0]       src_waddr_i,
  input  logic [XLEN*NUM_SRC-1:0]    src_wdata_i,
  input  logic [NUM_SRC-1:0]         src_wen_i,
  input  logic [XLEN*NUM_SRC-1:0]    src_inst_addr_i,
  input  logic                       wb_stall_i,
  output logic [4:0]                 reg_waddr_o,
  output logic [XLEN-1:0]            reg_wdata_o,
  output logic                       reg_wen_o,
  output logic [XLEN-1:0]            inst_addr_o,
  output logic                       commit_o,
  output logic [63:0]                retire_cnt_o,
  input  logic [4:0]                 chk_raddr_i,
  output logic                       chk_hit_o,
  output logic [XLEN-1:0]            chk_data_o,
  output logic [$clog2(DEPTH):0]     q_count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  logic [4:0]      q_waddr [DEPTH];
  logic [XLEN-1:0] q_wdata [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic            q_wen   [DEPTH];
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rr_ptr;
  logic [NUM_SRC-1:0] grant;
  logic            found, full, push, pop;
  int              gidx;
  always_comb begin
    found = 1'b0;
    gidx  = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found && src_valid_i[(int'(rr_ptr) + k) % NUM_SRC]) begin
        found = 1'b1;
        gidx  = (int'(rr_ptr) + k) % NUM_SRC;
      end
    end
    grant = found ? NUM_SRC'(1) << gidx : '0;
  end
  // ready looks only at occupancy, never at the stall, so a pop cannot open a slot the same cycle
  assign full        = count == CW'(DEPTH);
  assign src_ready_o = full ? '0 : grant;
  assign push        = found && !full;
  assign pop         = count != '0 && !wb_stall_i;
  assign q_count_o   = count;
  always_ff @(posedge clk) begin
    if (push) begin
      q_waddr[tail] <= src_waddr_i[5*gidx +: 5];
      q_wdata[tail] <= src_wdata_i[XLEN*gidx +: XLEN];
      q_pc[tail]    <= src_inst_addr_i[XLEN*gidx +: XLEN];
      q_wen[tail]   <= src_wen_i[gidx];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      rr_ptr       <= '0;
      reg_waddr_o  <= '0;
      reg_wdata_o  <= '0;
      reg_wen_o    <= 1'b0;
      inst_addr_o  <= '0;
      commit_o     <= 1'b0;
      retire_cnt_o <= '0;
    end else begin
      if (push) begin
        tail   <= tail + AW'(1);
        rr_ptr <= PW'((gidx + 1) % NUM_SRC);
      end
      count     <= count + CW'(push) - CW'(pop);
      commit_o  <= pop;
      reg_wen_o <= pop && q_wen[head] && q_waddr[head] != 5'd0;
      if (pop) begin
        head         <= head + AW'(1);
        reg_waddr_o  <= q_waddr[head];
        reg_wdata_o  <= q_wdata[head];
        inst_addr_o  <= q_pc[head];
        retire_cnt_o <= retire_cnt_o + 64'd1;
      end
    end
  end
  // scan oldest to youngest so the youngest match overwrites; output register is oldest of all
  always_comb begin
    chk_hit_o  = reg_wen_o && reg_waddr_o == chk_raddr_i;
    chk_data_o = chk_hit_o ? reg_wdata_o : '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count && q_wen[head + AW'(i)] && q_waddr[head + AW'(i)] == chk_raddr_i) begin
        chk_hit_o  = 1'b1;
        chk_data_o = q_wdata[head + AW'(i)];
      end
    end
    if (chk_raddr_i == 5'd0) begin
      chk_hit_o  = 1'b0;
      chk_data_o = '0;
    end
  end
endmodule

// File: tb/tb_wb_arb_queue.sv
// tb_wb_arb_queue: directed stimulus for wb_arb_queue checked every cycle against a
// queue-based behavioural model, plus hand-computed literal expectations.
module tb_wb_arb_queue;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   src_valid = '0, src_ready, src_wen = '0;
  logic [14:0]  src_waddr = '0;
  logic [191:0] src_wdata = '0, src_pc = '0;
  logic         wb_stall = 1'b0;
  logic [4:0]   reg_waddr, chk_raddr = '0;
  logic [63:0]  reg_wdata, inst_addr, retire_cnt, chk_data;
  logic         reg_wen, commit, chk_hit;
  logic [2:0]   q_count;
  int checks = 0, errors = 0;

  wb_arb_queue dut (
    .clk(clk), .rst(rst),
    .src_valid_i(src_valid), .src_ready_o(src_ready), .src_waddr_i(src_waddr),
    .src_wdata_i(src_wdata), .src_wen_i(src_wen), .src_inst_addr_i(src_pc),
    .wb_stall_i(wb_stall),
    .reg_waddr_o(reg_waddr), .reg_wdata_o(reg_wdata), .reg_wen_o(reg_wen),
    .inst_addr_o(inst_addr), .commit_o(commit), .retire_cnt_o(retire_cnt),
    .chk_raddr_i(chk_raddr), .chk_hit_o(chk_hit), .chk_data_o(chk_data),
    .q_count_o(q_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] a; logic [63:0] d; logic w; logic [63:0] pc; } ent_t;
  ent_t        m_q[$];
  int          m_rr = 0;
  logic [4:0]  m_waddr = '0;
  logic [63:0] m_wdata = '0, m_pc = '0, m_cnt = '0;
  logic        m_wen = 1'b0, m_commit = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < 3; k++)
      if (src_valid[(m_rr + k) % 3]) return (m_rr + k) % 3;
    return -1;
  endfunction

  // model: the queue and the registered output stage, updated on every clock edge
  initial forever begin : model
    int g;
    bit pu;
    ent_t e;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_q.delete(); m_rr = 0; m_waddr = '0; m_wdata = '0; m_pc = '0;
      m_wen = 1'b0; m_commit = 1'b0; m_cnt = '0;
    end else begin
      g  = pick();
      pu = g >= 0 && m_q.size() < 4;
      if (!wb_stall && m_q.size() > 0) begin
        e = m_q.pop_front();
        m_waddr = e.a; m_wdata = e.d; m_pc = e.pc;
        m_wen = e.w && e.a != 5'd0; m_commit = 1'b1; m_cnt = m_cnt + 64'd1;
      end else begin
        m_wen = 1'b0; m_commit = 1'b0;
      end
      if (pu) begin
        e.a = src_waddr[5*g +: 5]; e.d = src_wdata[64*g +: 64];
        e.w = src_wen[g]; e.pc = src_pc[64*g +: 64];
        m_q.push_back(e);
        m_rr = (g + 1) % 3;
      end
    end
  end

  initial forever begin : compare
    int g;
    logic [2:0] er;
    logic fh;
    logic [63:0] fd;
    @(negedge clk);
    g  = pick();
    er = (g >= 0 && m_q.size() < 4) ? 3'b001 << g : 3'b000;
    fh = m_wen && m_waddr == chk_raddr;
    fd = fh ? m_wdata : '0;
    foreach (m_q[i]) if (m_q[i].w && m_q[i].a == chk_raddr) begin fh = 1'b1; fd = m_q[i].d; end
    if (chk_raddr == 5'd0) begin fh = 1'b0; fd = '0; end
    chk("ready", src_ready, er);
    chk("waddr", reg_waddr, m_waddr);
    chk("wdata", reg_wdata, m_wdata);
    chk("wen", reg_wen, m_wen);
    chk("pc", inst_addr, m_pc);
    chk("commit", commit, m_commit);
    chk("retire_cnt", retire_cnt, m_cnt);
    chk("chk_hit", chk_hit, fh);
    chk("chk_data", chk_data, fd);
    chk("q_count", q_count, m_q.size());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input bit v, input logic [4:0] a, input logic [63:0] d,
                         input bit w, input logic [63:0] pc);
    src_valid[i] = v; src_waddr[5*i +: 5] = a; src_wdata[64*i +: 64] = d;
    src_wen[i] = w; src_pc[64*i +: 64] = pc;
  endtask

  initial begin
    int n;
    bit acc;
    logic [4:0] got[$];
    repeat (2) step();
    chk("rst_q_count", q_count, 0);
    chk("rst_cnt", retire_cnt, 0);
    chk("rst_commit", commit, 0);
    rst = 1'b0;
    // single push
    set_src(0, 1, 5, 64'h1234, 1, 64'h8000_0000);
    step();
    set_src(0, 0, 0, 0, 0, 0);
    step();
    chk("sp_wen", reg_wen, 1);
    chk("sp_waddr", reg_waddr, 5);
    chk("sp_wdata", reg_wdata, 64'h1234);
    chk("sp_pc", inst_addr, 64'h8000_0000);
    chk("sp_commit", commit, 1);
    chk("sp_cnt", retire_cnt, 1);
    step();
    chk("sp_commit_low", commit, 0);
    // contention from reset: accepts rotate 0,1,2,...
    rst = 1'b1; #2; rst = 1'b0;
    for (int i = 0; i < 3; i++) set_src(i, 1, 5'(10 + i), 64'h100 + 64'(i), 1, 64'h8000_1000 + 64'(4*i));
    step();
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_order", reg_waddr, 10 + k % 3);
      chk("rr_commit", commit, 1);
    end
    for (int i = 0; i < 3; i++) set_src(i, 0, 0, 0, 0, 0);
    repeat (4) step();
    chk("rr_cnt", retire_cnt, 7);
    // backpressure: stall fills the queue, then drains in order
    n = 1;
    wb_stall = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc == 10) wb_stall = 1'b0;
      if (n <= 5) set_src(0, 1, 5'(n), 64'(n) * 16, 1, 64'h8000_2000 + 64'(n));
      else set_src(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      acc = src_valid[0] && src_ready[0];
      if (cyc == 9) begin
        chk("bp_count", q_count, 4);
        chk("bp_ready", src_ready, 0);
      end
      step();
      if (acc) n++;
      if (commit) got.push_back(reg_waddr);
    end
    chk("bp_num", got.size(), 5);
    foreach (got[i]) chk("bp_seq", got[i], i + 1);
    // x0 and no-write retirements
    set_src(1, 1, 0, 64'hFFFF, 1, 64'h8000_3000);
    step();
    set_src(1, 0, 0, 0, 0, 0);
    set_src(2, 1, 3, 64'h55, 0, 64'h8000_3004);
    #1;
    chk("x0_hit", chk_hit, 0);
    step();
    chk("x0_commit", commit, 1);
    chk("x0_wen", reg_wen, 0);
    set_src(2, 0, 0, 0, 0, 0);
    step();
    chk("nw_commit", commit, 1);
    chk("nw_wen", reg_wen, 0);
    chk("nw_cnt", retire_cnt, 14);
    // forwarding: youngest pending write wins, then output register
    chk_raddr = 7;
    wb_stall = 1'b1;
    set_src(0, 1, 7, 64'hA, 1, 64'h8000_4000);
    step();
    set_src(0, 1, 7, 64'hB, 1, 64'h8000_4004);
    step();
    set_src(0, 0, 0, 0, 0, 0);
    #1;
    chk("fw_q_hit", chk_hit, 1);
    chk("fw_q_data", chk_data, 64'hB);
    chk("fw_q_count", q_count, 2);
    wb_stall = 1'b0;
    step();
    chk("fw_mix_hit", chk_hit, 1);
    chk("fw_mix_data", chk_data, 64'hB);
    step();
    chk("fw_out_hit", chk_hit, 1);
    chk("fw_out_data", chk_data, 64'hB);
    step();
    chk("fw_gone_hit", chk_hit, 0);
    chk("fw_gone_data", chk_data, 0);
    // reset with entries pending
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_src(0, 1, 5'(9 + i), 64'hC0 + 64'(i), 1, 64'h8000_5000 + 64'(4*i));
      step();
    end
    set_src(0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_wdata", reg_wdata, 0);
    chk("ar_pc", inst_addr, 0);
    chk("ar_cnt", retire_cnt, 0);
    chk("ar_q_count", q_count, 0);
    #1;
    rst = 1'b0;
    wb_stall = 1'b0;
    repeat (3) begin
      step();
      chk("post_rst_wen", reg_wen, 0);
      chk("post_rst_commit", commit, 0);
    end
    chk("post_rst_cnt", retire_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
